// File: rtl/ip_color_pkg.sv
// Shared colour-space constants, monitor state encoding and sync bundle.
package ip_color_pkg;

  // YCbCr -> RGB (BT.601 full range), Q2.10
  localparam int COEF_FRAC = 10;
  localparam int COEF_W    = 12;   // signed width holding the largest coefficient
  localparam int C_R_CR    = 1436;
  localparam int C_G_CB    = 352;
  localparam int C_G_CR    = 731;
  localparam int C_B_CB    = 1815;

  // RGB -> YCbCr companion coefficients (magnitudes; subtract terms noted)
  localparam int C_Y_R  = 306;
  localparam int C_Y_G  = 601;
  localparam int C_Y_B  = 117;
  localparam int C_CB_R = 173;   // subtracted
  localparam int C_CB_G = 339;   // subtracted
  localparam int C_CB_B = 512;
  localparam int C_CR_R = 512;
  localparam int C_CR_G = 429;   // subtracted
  localparam int C_CR_B = 83;    // subtracted

  // datapath latency, shared by the sync delay line
  localparam int SYNC_DLY = 3;

  // frame monitor: SKIP = inside a frame while dropping a line cut by a restart
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_SKIP  = 2'd2
  } mon_st_e;

  // control bits that travel alongside the pixel pipeline
  typedef struct packed {
    logic frm_err;
    logic vend;
    logic vstr;
    logic href;
  } sync_t;

endpackage

// File: rtl/ip_sync_dly.sv
// Fixed-depth register delay line for sync/control bits.
module ip_sync_dly #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] dly_pipe;

  // shift register; element 0 is the youngest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_pipe <= '0;
    end else begin
      dly_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) dly_pipe[i] <= dly_pipe[i-1];
    end
  end

  assign dout = dly_pipe[DEPTH-1];

endmodule

// File: rtl/ip_yuv2rgb.sv
// YCbCr -> RGB converter, 3-stage pipeline, with line/frame geometry monitor.
module ip_yuv2rgb #(
  parameter int DAT_SZ    = 10,
  parameter int COEF_FRAC = ip_color_pkg::COEF_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_href,
  input  logic              i_vstr,
  input  logic              i_vend,
  input  logic [DAT_SZ-1:0] i_data_y,
  input  logic [DAT_SZ-1:0] i_data_cb,
  input  logic [DAT_SZ-1:0] i_data_cr,
  input  logic [15:0]       i_hwin_sz,
  input  logic [15:0]       i_vwin_sz,
  output logic              o_href,
  output logic              o_vstr,
  output logic              o_vend,
  output logic [DAT_SZ-1:0] o_data_r,
  output logic [DAT_SZ-1:0] o_data_g,
  output logic [DAT_SZ-1:0] o_data_b,
  output logic              o_line_err,
  output logic              o_frm_err
);

  import ip_color_pkg::*;

  localparam int DW = DAT_SZ + 1;     // signed component width
  localparam int PW = DW + COEF_W;    // full product width
  localparam int SW = PW + 3;         // stage-3 sum width, never overflows

  localparam logic signed [DW-1:0] HALF  = DW'(1 << (DAT_SZ - 1));
  localparam logic signed [SW-1:0] RND   = SW'(1 << (COEF_FRAC - 1));
  localparam logic signed [SW-1:0] MAXV  = SW'((1 << DAT_SZ) - 1);
  localparam logic signed [PW-1:0] K_RCR = PW'(C_R_CR);
  localparam logic signed [PW-1:0] K_GCB = PW'(C_G_CB);
  localparam logic signed [PW-1:0] K_GCR = PW'(C_G_CR);
  localparam logic signed [PW-1:0] K_BCB = PW'(C_B_CB);

  function automatic logic [DAT_SZ-1:0] clip(input logic signed [SW-1:0] v);
    if (v < 0)         clip = '0;
    else if (v > MAXV) clip = '1;
    else               clip = v[DAT_SZ-1:0];
  endfunction

  // ---------------- datapath ----------------
  logic signed [DW-1:0] y1, dcb1, dcr1, y2;
  logic signed [PW-1:0] p_rcr, p_gcb, p_gcr, p_bcb;
  logic signed [SW-1:0] r_sum, g_sum, b_sum;
  logic [DAT_SZ-1:0]    r3, g3, b3;

  // stage 1: recentre chroma around zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1   <= '0;
      dcb1 <= '0;
      dcr1 <= '0;
    end else begin
      y1   <= {1'b0, i_data_y};
      dcb1 <= $signed({1'b0, i_data_cb}) - HALF;
      dcr1 <= $signed({1'b0, i_data_cr}) - HALF;
    end
  end

  // stage 2: full-precision coefficient products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y2    <= '0;
      p_rcr <= '0;
      p_gcb <= '0;
      p_gcr <= '0;
      p_bcb <= '0;
    end else begin
      y2    <= y1;
      p_rcr <= PW'(dcr1) * K_RCR;
      p_gcb <= PW'(dcb1) * K_GCB;
      p_gcr <= PW'(dcr1) * K_GCR;
      p_bcb <= PW'(dcb1) * K_BCB;
    end
  end

  assign r_sum = SW'(y2) + ((SW'(p_rcr) + RND) >>> COEF_FRAC);
  assign g_sum = SW'(y2) - ((SW'(p_gcb) + SW'(p_gcr) + RND) >>> COEF_FRAC);
  assign b_sum = SW'(y2) + ((SW'(p_bcb) + RND) >>> COEF_FRAC);

  // stage 3: round, clip, register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3 <= '0;
      g3 <= '0;
      b3 <= '0;
    end else begin
      r3 <= clip(r_sum);
      g3 <= clip(g_sum);
      b3 <= clip(b_sum);
    end
  end

  // ---------------- geometry monitor ----------------
  mon_st_e     state, state_nx;
  logic        href_d, fall;
  logic [15:0] pix_cnt, line_cnt, line_cnt_nx;
  logic        line_chk, line_inc, line_bad, frm_err_p, line_err;

  assign fall        = href_d & ~i_href;
  // a restart in the same cycle discards whatever line just ended
  assign line_chk    = fall & ~i_vstr & (state != ST_SKIP);
  assign line_inc    = fall & ~i_vstr & (state == ST_FRAME);
  assign line_bad    = line_chk & (pix_cnt != i_hwin_sz);
  assign line_cnt_nx = line_cnt + 16'(line_inc);
  assign frm_err_p   = i_vend & ~i_vstr & (state != ST_IDLE) & (line_cnt_nx != i_vwin_sz);

  // monitor state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next state: vstr restarts from any state, vend closes an open frame
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (i_vstr) state_nx = i_href ? ST_SKIP : ST_FRAME;
      end
      ST_FRAME: begin
        if (i_vstr)      state_nx = i_href ? ST_SKIP : ST_FRAME;
        else if (i_vend) state_nx = ST_IDLE;
      end
      ST_SKIP: begin
        if (i_vstr)      state_nx = i_href ? ST_SKIP : ST_FRAME;
        else if (i_vend) state_nx = ST_IDLE;
        else if (fall)   state_nx = ST_FRAME;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // pixel/line counters and sticky line error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d   <= 1'b0;
      pix_cnt  <= '0;
      line_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      href_d <= i_href;
      if (i_vstr) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        line_err <= 1'b0;
      end else begin
        line_cnt <= line_cnt_nx;
        line_err <= line_err | line_bad;
        if (fall)                               pix_cnt <= '0;
        else if (i_href && pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
      end
    end
  end

  // ---------------- sync alignment ----------------
  sync_t sync_in, sync_out;

  assign sync_in.frm_err = frm_err_p;
  assign sync_in.vend    = i_vend;
  assign sync_in.vstr    = i_vstr;
  assign sync_in.href    = i_href;

  ip_sync_dly #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (SYNC_DLY)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_in),
    .dout  (sync_out)
  );

  assign o_href     = sync_out.href;
  assign o_vstr     = sync_out.vstr;
  assign o_vend     = sync_out.vend;
  assign o_frm_err  = sync_out.frm_err;
  assign o_line_err = line_err;
  assign o_data_r   = o_href ? r3 : '0;
  assign o_data_g   = o_href ? g3 : '0;
  assign o_data_b   = o_href ? b3 : '0;

endmodule

// File: tb/tb_ip_yuv2rgb.sv
// Self-checking bench for ip_yuv2rgb against a behavioural frame/pixel model.
module tb_ip_yuv2rgb;

  localparam int DZ   = 10;
  localparam int MAXC = (1 << DZ) - 1;
  localparam int HALF = 1 << (DZ - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_href = 1'b0, i_vstr = 1'b0, i_vend = 1'b0;
  logic [DZ-1:0] i_data_y = '0, i_data_cb = '0, i_data_cr = '0;
  logic [15:0]   i_hwin_sz = 16'd64, i_vwin_sz = 16'd8;
  logic          o_href, o_vstr, o_vend, o_line_err, o_frm_err;
  logic [DZ-1:0] o_data_r, o_data_g, o_data_b;

  always #5 clk = ~clk;

  ip_yuv2rgb #(.DAT_SZ(DZ), .COEF_FRAC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_href(i_href), .i_vstr(i_vstr), .i_vend(i_vend),
    .i_data_y(i_data_y), .i_data_cb(i_data_cb), .i_data_cr(i_data_cr),
    .i_hwin_sz(i_hwin_sz), .i_vwin_sz(i_vwin_sz),
    .o_href(o_href), .o_vstr(o_vstr), .o_vend(o_vend),
    .o_data_r(o_data_r), .o_data_g(o_data_g), .o_data_b(o_data_b),
    .o_line_err(o_line_err), .o_frm_err(o_frm_err)
  );

  typedef struct {
    bit href, vstr, vend, ferr;
    int r, g, b;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0, n_err = 0, ferr_seen = 0;

  // model state: frame open, dropping a cut line, previous href, counts, sticky error
  bit m_frm, m_skip, m_href_d, m_lerr;
  int m_pix, m_lines;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int clipc(input int v);
    return (v < 0) ? 0 : (v > MAXC) ? MAXC : v;
  endfunction

  task automatic mdl_reset();
    exp_t z;
    z = '{0, 0, 0, 0, 0, 0, 0};
    m_frm = 0; m_skip = 0; m_href_d = 0; m_lerr = 0; m_pix = 0; m_lines = 0;
    expq.delete();
    expq.push_back(z);
    expq.push_back(z);
  endtask

  // apply one cycle of input, advance the model, compare outputs after the edge
  task automatic step(input bit h, input bit vs, input bit ve, input int y, input int cb, input int cr);
    exp_t e;
    bit   fall, ferr;
    int   dcb, dcr;
    i_href = h; i_vstr = vs; i_vend = ve;
    i_data_y = DZ'(y); i_data_cb = DZ'(cb); i_data_cr = DZ'(cr);

    fall = m_href_d && !h;
    ferr = 0;
    if (vs) begin
      m_lerr = 0; m_lines = 0; m_pix = 0; m_frm = 1; m_skip = h;
    end else begin
      if (fall) begin
        if (!m_skip) begin
          if (m_pix != int'(i_hwin_sz)) m_lerr = 1;
          if (m_frm) m_lines++;
        end
        m_skip = 0;
        m_pix  = 0;
      end else if (h) begin
        m_pix = (m_pix < 65535) ? m_pix + 1 : 65535;
      end
      if (ve && m_frm) begin
        ferr   = (m_lines != int'(i_vwin_sz));
        m_frm  = 0;
        m_skip = 0;
      end
    end
    m_href_d = h;

    dcb = cb - HALF;
    dcr = cr - HALF;
    e.href = h; e.vstr = vs; e.vend = ve; e.ferr = ferr;
    e.r = h ? clipc(y + fdiv(1436 * dcr + 512, 1024)) : 0;
    e.g = h ? clipc(y - fdiv(352 * dcb + 731 * dcr + 512, 1024)) : 0;
    e.b = h ? clipc(y + fdiv(1815 * dcb + 512, 1024)) : 0;
    expq.push_back(e);

    @(posedge clk);
    #1;
    e = expq.pop_front();
    if (o_frm_err === 1'b1) ferr_seen++;
    chk("o_href",     o_href,     e.href);
    chk("o_vstr",     o_vstr,     e.vstr);
    chk("o_vend",     o_vend,     e.vend);
    chk("o_frm_err",  o_frm_err,  e.ferr);
    chk("o_data_r",   o_data_r,   e.r);
    chk("o_data_g",   o_data_g,   e.g);
    chk("o_data_b",   o_data_b,   e.b);
    chk("o_line_err", o_line_err, m_lerr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
  endtask

  task automatic line(input int npix);
    for (int i = 0; i < npix; i++) step(1, 0, 0, $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    idle(4);
  endtask

  // known-answer pixel: visible two steps after the step that applies it
  task automatic kat(input string tag, input int y, input int cb, input int cr, input int r, input int g, input int b);
    step(1, 0, 0, y, cb, cr);
    idle(2);
    chk({tag, "_r"}, o_data_r, r);
    chk({tag, "_g"}, o_data_g, g);
    chk({tag, "_b"}, o_data_b, b);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_href"}, o_href, 0);
    chk({tag, "_vstr"}, o_vstr, 0);
    chk({tag, "_vend"}, o_vend, 0);
    chk({tag, "_r"},    o_data_r, 0);
    chk({tag, "_g"},    o_data_g, 0);
    chk({tag, "_b"},    o_data_b, 0);
    chk({tag, "_lerr"}, o_line_err, 0);
    chk({tag, "_ferr"}, o_frm_err, 0);
  endtask

  initial begin
    bit h;

    // power-on reset
    #12;
    check_outputs_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_reset();

    // known answers, including clip high and clip low
    kat("kat_mid",  512,  512,  512, 512,  512,  512);
    kat("kat_hi",   1023, 512,  1023, 1023, 658, 1023);
    kat("kat_lo",   0,    0,    512, 0,    176,  0);
    idle(3);

    // clean frame: 8 lines of 64
    i_hwin_sz = 16'd64; i_vwin_sz = 16'd8;
    ferr_seen = 0;
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    for (int l = 0; l < 8; l++) line(64);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("good_frm_lerr", o_line_err, 0);
    chk("good_frm_ferr_cnt", ferr_seen, 0);

    // bad frame: line 3 has 63 pixels, only 7 lines
    ferr_seen = 0;
    step(0, 1, 0, 0, 0, 0);
    idle(2);
    for (int l = 0; l < 7; l++) line((l == 2) ? 63 : 64);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("bad_frm_lerr", o_line_err, 1);
    chk("bad_frm_ferr_cnt", ferr_seen, 1);

    // restart mid-line: the cut line is dropped, then 8 clean lines
    ferr_seen = 0;
    step(0, 1, 0, 0, 0, 0);
    idle(1);
    line(64);
    for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    step(1, 1, 0, 100, 200, 300);
    for (int i = 0; i < 20; i++) step(1, 0, 0, $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    idle(4);
    for (int l = 0; l < 8; l++) line(64);
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("restart_lerr", o_line_err, 0);
    chk("restart_ferr_cnt", ferr_seen, 0);

    // random traffic with short geometry so mismatches go both ways
    i_hwin_sz = 16'd5; i_vwin_sz = 16'd3;
    h = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) h = ~h;
      step(h, $urandom_range(0, 79) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    end

    // reset mid-line
    i_hwin_sz = 16'd64; i_vwin_sz = 16'd8;
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, $urandom_range(0, MAXC), $urandom_range(0, MAXC), $urandom_range(0, MAXC));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    @(posedge clk); @(posedge clk); #1;
    check_outputs_zero("rst_hold");
    i_href = 0; i_vstr = 0; i_vend = 0;
    rst_n = 1'b1;
    mdl_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_href", o_href, 0);
    end
    // a frame end with no frame open must not raise a frame error
    ferr_seen = 0;
    step(0, 0, 1, 0, 0, 0);
    idle(4);
    chk("post_rst_ferr_cnt", ferr_seen, 0);
    chk("post_rst_lerr", o_line_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
